// File: rtl/rr_reg_write_arbiter_if.sv
// Bus between the four write requesters and the round-robin register write arbiter.
// The arbiter takes the slave side; the requesters (or a bench) take the master side.
interface rr_reg_write_arbiter_if #(
   parameter int WIDTH = 8
);
   logic [3:0]         req;
   logic [4*WIDTH-1:0] wdata;
   logic [3:0]         ack;
   logic               reg_en;
   logic [WIDTH-1:0]   reg_d;
   logic [WIDTH-1:0]   q;
   logic [1:0]         owner;
   logic               busy;

   modport master (
      output req, wdata,
      input  ack, reg_en, reg_d, q, owner, busy
   );

   modport slave (
      input  req, wdata,
      output ack, reg_en, reg_d, q, owner, busy
   );
endinterface

// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter granting four requesters write access to one shared register,
// with a one-cycle write, a one-cycle ack and a programmable idle gap between grants.
module rr_reg_write_arbiter #(
   parameter int WIDTH = 8,
   parameter int GAP   = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   rr_reg_write_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   localparam logic [3:0] GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

   state_t           state_q;
   logic [1:0]       ptr_q;
   logic [3:0]       cnt_q;
   logic [3:0]       ack_q;
   logic             reg_en_q;
   logic [WIDTH-1:0] reg_d_q;
   logic [WIDTH-1:0] q_q;
   logic [1:0]       owner_q;
   logic             busy_q;

   logic [1:0]       win_d;
   logic [WIDTH-1:0] wsel_d;

   // Circular search starting at p; scanning offsets high-to-low lets the
   // nearest set bit overwrite farther ones.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic [1:0] best;
      best = p;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) best = idx;
      end
      return best;
   endfunction

   always_comb begin
      win_d  = rr_pick(bus.req, ptr_q);
      wsel_d = bus.wdata[win_d*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= 2'd0;
         cnt_q    <= 4'd0;
         ack_q    <= 4'd0;
         reg_en_q <= 1'b0;
         reg_d_q  <= '0;
         q_q      <= '0;
         owner_q  <= 2'd0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|bus.req) begin
                  reg_d_q  <= wsel_d;
                  reg_en_q <= 1'b1;
                  ack_q    <= 4'b0001 << win_d;
                  owner_q  <= win_d;
                  ptr_q    <= win_d + 2'd1;
                  busy_q   <= 1'b1;
                  state_q  <= S_WRITE;
               end
            end
            // The shared register captures reg_d at the edge that closes WRITE.
            S_WRITE: begin
               q_q      <= reg_d_q;
               reg_en_q <= 1'b0;
               ack_q    <= 4'd0;
               if (GAP == 0) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q   <= GAP_LOAD;
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               if (cnt_q == 4'd0) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               reg_en_q <= 1'b0;
               ack_q    <= 4'd0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ack    = ack_q;
   assign bus.reg_en = reg_en_q;
   assign bus.reg_d  = reg_d_q;
   assign bus.q      = q_q;
   assign bus.owner  = owner_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Directed bench for rr_reg_write_arbiter: one instance with GAP=1, one with GAP=0,
// expected grants queued on stimulus and checked when the ack appears.
module tb_rr_reg_write_arbiter;
   localparam int WIDTH = 8;

   typedef struct packed {
      logic [1:0]       who;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   last_g = 0;
   int   period = 0;
   logic use0 = 1'b1;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rr_reg_write_arbiter_if #(.WIDTH(WIDTH)) b0 ();
   rr_reg_write_arbiter_if #(.WIDTH(WIDTH)) b1 ();

   rr_reg_write_arbiter #(.WIDTH(WIDTH), .GAP(1)) dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b0.slave)
   );

   rr_reg_write_arbiter #(.WIDTH(WIDTH), .GAP(0)) dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b1.slave)
   );

   wire [3:0]       o_ack    = use0 ? b0.ack    : b1.ack;
   wire [1:0]       o_owner  = use0 ? b0.owner  : b1.owner;
   wire [WIDTH-1:0] o_reg_d  = use0 ? b0.reg_d  : b1.reg_d;
   wire [WIDTH-1:0] o_q      = use0 ? b0.q      : b1.q;
   wire             o_reg_en = use0 ? b0.reg_en : b1.reg_en;
   wire             o_busy   = use0 ? b0.busy   : b1.busy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                           input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
      if (use0) b0.wdata = {d3, d2, d1, d0};
      else      b1.wdata = {d3, d2, d1, d0};
   endtask

   task automatic push(input logic [1:0] who, input logic [WIDTH-1:0] data);
      exp_t e;
      e.who  = who;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Waits (bounded) for the next ack, checks it against the oldest queued grant,
   // then checks the register content one edge later.
   task automatic wait_grant(input string tag);
      int   n = 0;
      exp_t e;
      while (o_ack == 4'd0 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_in_time"}, 32'(n < 20), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      period = cyc - last_g;
      last_g = cyc;
      chk({tag, "_ack"},    32'(o_ack),    32'(4'b0001 << e.who));
      chk({tag, "_owner"},  32'(o_owner),  32'(e.who));
      chk({tag, "_reg_d"},  32'(o_reg_d),  32'(e.data));
      chk({tag, "_reg_en"}, 32'(o_reg_en), 32'd1);
      chk({tag, "_busy"},   32'(o_busy),   32'd1);
      tick();
      chk({tag, "_q"},        32'(o_q),      32'(e.data));
      chk({tag, "_ack_drop"}, 32'(o_ack),    32'd0);
      chk({tag, "_en_drop"},  32'(o_reg_en), 32'd0);
   endtask

   initial begin
      reset_n  = 1'b0;
      b0.req   = 4'hF;
      b1.req   = 4'hF;
      b0.wdata = 32'hDEADBEEF;
      b1.wdata = 32'hCAFEF00D;

      // Reset held two cycles with all requests high.
      tick();
      tick();
      chk("rst_q",      32'(b0.q),      32'd0);
      chk("rst_ack",    32'(b0.ack),    32'd0);
      chk("rst_reg_en", 32'(b0.reg_en), 32'd0);
      chk("rst_busy",   32'(b0.busy),   32'd0);
      chk("rst_owner",  32'(b0.owner),  32'd0);
      chk("rst_reg_d",  32'(b0.reg_d),  32'd0);
      chk("rst_q1",     32'(b1.q),      32'd0);
      chk("rst_ack1",   32'(b1.ack),    32'd0);
      b0.req = 4'h0;
      b1.req = 4'h0;
      reset_n = 1'b1;
      tick();
      chk("idle_ack", 32'(b0.ack), 32'd0);

      // Fairness: all four held, grants rotate 0,1,2,3,0 every 3 cycles.
      use0 = 1'b1;
      set_data(8'h11, 8'h22, 8'h33, 8'h44);
      b0.req = 4'hF;
      push(2'd0, 8'h11);
      push(2'd1, 8'h22);
      push(2'd2, 8'h33);
      push(2'd3, 8'h44);
      push(2'd0, 8'h11);
      for (int i = 0; i < 5; i++) begin
         wait_grant("fair");
         if (i > 0) chk("fair_period", 32'(period), 32'd3);
      end
      b0.req = 4'h0;

      // Single request from requester 2.
      set_data(8'h00, 8'h00, 8'hA5, 8'h00);
      b0.req = 4'b0100;
      push(2'd2, 8'hA5);
      wait_grant("single");
      b0.req = 4'h0;
      tick();
      chk("single_busy_clr", 32'(b0.busy),  32'd0);
      chk("single_owner",    32'(b0.owner), 32'd2);
      chk("single_q_hold",   32'(b0.q),     32'hA5);

      // Wrap/skip: pointer at 3, requesters 0 and 1 -> 0 then 1.
      set_data(8'h10, 8'h20, 8'hEE, 8'hFF);
      b0.req = 4'b0011;
      push(2'd0, 8'h10);
      push(2'd1, 8'h20);
      wait_grant("wrap0");
      wait_grant("wrap1");
      b0.req = 4'h0;

      // GAP=0 instance: alternating grants every 2 cycles, then req[1] dropped.
      use0 = 1'b0;
      set_data(8'h5A, 8'hC3, 8'h00, 8'h00);
      b1.req = 4'b0011;
      push(2'd0, 8'h5A);
      push(2'd1, 8'hC3);
      push(2'd0, 8'h5A);
      for (int i = 0; i < 3; i++) begin
         wait_grant("gap0");
         if (i > 0) chk("gap0_period", 32'(period), 32'd2);
      end
      b1.req = 4'b0000;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("drop_no_ack", 32'(b1.ack), 32'd0);
      end
      chk("drop_q_keep",  32'(b1.q),     32'h5A);
      chk("drop_owner",   32'(b1.owner), 32'd0);
      chk("drop_busy",    32'(b1.busy),  32'd0);

      // Mid-operation reset during WRITE: write aborted, pointer back to 0.
      use0 = 1'b1;
      set_data(8'h77, 8'h00, 8'h00, 8'h00);
      b0.req = 4'b0001;
      tick();
      chk("mid_ack",    32'(b0.ack),    32'h1);
      chk("mid_reg_en", 32'(b0.reg_en), 32'd1);
      b0.req  = 4'h0;
      reset_n = 1'b0;
      tick();
      chk("mid_q",      32'(b0.q),      32'd0);
      chk("mid_ack0",   32'(b0.ack),    32'd0);
      chk("mid_en0",    32'(b0.reg_en), 32'd0);
      chk("mid_busy0",  32'(b0.busy),   32'd0);
      chk("mid_owner0", 32'(b0.owner),  32'd0);
      reset_n = 1'b1;
      tick();
      chk("mid_q_hold", 32'(b0.q), 32'd0);
      set_data(8'h61, 8'h62, 8'h63, 8'h64);
      b0.req = 4'b0101;
      push(2'd0, 8'h61);
      wait_grant("post_rst");
      b0.req = 4'h0;

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
